// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: watches a scanned 7-segment bus (segments + one-hot digit
// strobe). Each digit is accepted only after it has been stable for STABLE
// cycles, decoded back to a hex nibble, and NDIG digits are assembled into a
// frame that is presented through a valid/ready output.
module seg7_scan_capture #(
    parameter int unsigned NDIG   = 4,
    parameter int unsigned STABLE = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          seg_in,
    input  logic [NDIG-1:0]     dig_sel,
    output logic [4*NDIG-1:0]   value,
    output logic [NDIG-1:0]     dp_out,
    output logic                err,
    output logic                overrun,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int unsigned RUN_W = $clog2(STABLE + 1);
    localparam int unsigned IN_W  = NDIG + 8;
    localparam int unsigned VAL_W = 4 * NDIG;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE);

    // Dwell tracking
    logic [IN_W-1:0]   prev_q,    prev_d;
    logic [RUN_W-1:0]  run_q,     run_d;
    logic              done_q,    done_d;
    // Frame assembly
    logic [VAL_W-1:0]  slot_q,    slot_d;
    logic [NDIG-1:0]   dps_q,     dps_d;
    logic [NDIG-1:0]   seen_q,    seen_d;
    logic              err_acc_q, err_acc_d;
    // Output frame
    logic [VAL_W-1:0]  value_q,   value_d;
    logic [NDIG-1:0]   dp_q,      dp_d;
    logic              err_q,     err_d;
    logic              overrun_q, overrun_d;
    logic              valid_q,   valid_d;

    logic [3:0]        nib;
    logic              pat_ok;
    logic              sel_onehot;
    logic              same_in;
    logic              capture;
    logic              frame_done;
    logic [NDIG-1:0]   seen_nx;
    logic              err_nx;

    // Map segment pattern (dp masked) back to a hex nibble
    always_comb begin
        nib    = 4'h0;
        pat_ok = 1'b1;
        case ({seg_in[7:1], 1'b0})
            8'hFC:   nib = 4'h0;
            8'h60:   nib = 4'h1;
            8'hDA:   nib = 4'h2;
            8'hF2:   nib = 4'h3;
            8'h66:   nib = 4'h4;
            8'hB6:   nib = 4'h5;
            8'hBE:   nib = 4'h6;
            8'hE0:   nib = 4'h7;
            8'hFE:   nib = 4'h8;
            8'hF6:   nib = 4'h9;
            8'hEE:   nib = 4'hA;
            8'h3E:   nib = 4'hB;
            8'h1A:   nib = 4'hC;
            8'h7A:   nib = 4'hD;
            8'h9E:   nib = 4'hE;
            8'h8E:   nib = 4'hF;
            default: pat_ok = 1'b0;
        endcase
    end

    // Run-length count of identical one-hot inputs; single capture per dwell
    always_comb begin
        prev_d     = {dig_sel, seg_in};
        sel_onehot = $onehot(dig_sel);
        same_in    = ({dig_sel, seg_in} == prev_q);
        run_d      = '0;
        if (sel_onehot) begin
            if (same_in && (run_q != '0)) begin
                run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
            end else begin
                run_d = RUN_W'(1);
            end
        end
        capture = sel_onehot && (run_d == RUN_MAX) && !(same_in && done_q);
        done_d  = capture || (sel_onehot && same_in && done_q);
    end

    // Slot/seen/error accumulation and output frame handshake
    always_comb begin
        slot_d    = slot_q;
        dps_d     = dps_q;
        seen_nx   = seen_q;
        err_nx    = err_acc_q;
        value_d   = value_q;
        dp_d      = dp_q;
        err_d     = err_q;
        overrun_d = overrun_q;
        valid_d   = valid_q;

        if (capture) begin
            for (int unsigned i = 0; i < NDIG; i++) begin
                if (dig_sel[i]) begin
                    slot_d[4*i +: 4] = nib;
                    dps_d[i]         = seg_in[0];
                end
            end
            seen_nx = seen_q | dig_sel;
            err_nx  = err_acc_q | ~pat_ok;
        end

        frame_done = capture && (&seen_nx);
        seen_d     = frame_done ? '0   : seen_nx;
        err_acc_d  = frame_done ? 1'b0 : err_nx;

        if (frame_done) begin
            value_d = slot_d;
            dp_d    = dps_d;
            err_d   = err_nx;
            valid_d = 1'b1;
            // Overwriting a frame nobody took is an overrun; a same-edge
            // handshake means the old frame was consumed, so leave it alone
            if (valid_q && !out_ready) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q    <= '0;
            run_q     <= '0;
            done_q    <= 1'b0;
            slot_q    <= '0;
            dps_q     <= '0;
            seen_q    <= '0;
            err_acc_q <= 1'b0;
            value_q   <= '0;
            dp_q      <= '0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            run_q     <= run_d;
            done_q    <= done_d;
            slot_q    <= slot_d;
            dps_q     <= dps_d;
            seen_q    <= seen_d;
            err_acc_q <= err_acc_d;
            value_q   <= value_d;
            dp_q      <= dp_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
            valid_q   <= valid_d;
        end
    end

    assign value     = value_q;
    assign dp_out    = dp_q;
    assign err       = err_q;
    assign overrun   = overrun_q;
    assign out_valid = valid_q;

endmodule
